// File: rtl/tft_frame_capture.sv
// tft_frame_capture: RGB666 panel capture into an RGB565 write FIFO plus a paged SDRAM write-address counter.
// Define TFT_CAP_LINE_CHECK_EN to drop frames whose line pixel count differs from H_ACTIVE.
module tft_frame_capture #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 480,
  parameter int PAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture_en,
  input  logic        vin_dclk,
  input  logic        vin_de,
  input  logic        vin_vs,
  input  logic [5:0]  vin_r,
  input  logic [5:0]  vin_g,
  input  logic [5:0]  vin_b,
  output logic        fifo_wr_req,
  output logic [15:0] fifo_wr_data,
  input  logic        fifo_full,
  input  logic        wr_inc,
  output logic [8:0]  row_add_user,
  output logic [9:0]  col_add_user,
  output logic [2:0]  page_set,
  output logic        frame_done,
  output logic        overflow,
  output logic        line_err
);
  typedef enum logic [1:0] {IDLE, ARM, FRAME, DROP} state_t;
  localparam int LW = $clog2(V_ACTIVE + 1);
  state_t state, state_nx;
  logic [20:0] s1, s2;
  logic dclk_d, vs_d, p_valid, p_de, p_vs, last_de;
  logic [15:0] p_px;
  logic [LW-1:0] line_cnt;
  logic pix, line_end, last_line, bad_line, enter, wr, unused_lsb;
  assign unused_lsb = ^{s2[12], s2[0]};
  assign pix = p_valid & p_de;
  assign line_end = p_valid & ~p_de & last_de;
  assign last_line = line_cnt == LW'(V_ACTIVE - 1);
  assign enter = (state == ARM || state == DROP) && state_nx == FRAME;
  assign wr = state == FRAME && pix && !fifo_full;
`ifdef TFT_CAP_LINE_CHECK_EN
  localparam int PW = $clog2(H_ACTIVE + 1) + 1;
  logic [PW-1:0] pix_cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) pix_cnt <= '0;
    else pix_cnt <= (line_end || p_vs) ? '0 : pix_cnt + PW'(pix);
  assign bad_line = line_end && pix_cnt != PW'(H_ACTIVE);
`else
  assign bad_line = 1'b0;
`endif
  // s1/s2 carry {dclk, de, vs, r, g, b}; the p_* stage holds the sample taken on a dclk rise
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      dclk_d <= 1'b0;
      vs_d <= 1'b0;
      p_valid <= 1'b0;
      p_de <= 1'b0;
      p_vs <= 1'b0;
      p_px <= '0;
      last_de <= 1'b0;
    end else begin
      s1 <= {vin_dclk, vin_de, vin_vs, vin_r, vin_g, vin_b};
      s2 <= s1;
      dclk_d <= s2[20];
      vs_d <= s2[18];
      p_valid <= s2[20] & ~dclk_d;
      p_de <= s2[19];
      p_vs <= s2[18] & ~vs_d;
      p_px <= {s2[17:13], s2[11:6], s2[5:1]};
      if (p_valid) last_de <= p_de;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = capture_en ? ARM : IDLE;
      ARM, DROP: state_nx = !capture_en ? IDLE : p_vs ? FRAME : state;
      FRAME:
        if ((pix && fifo_full) || bad_line) state_nx = DROP;
        else if (p_vs) state_nx = capture_en ? FRAME : IDLE;
        else if (line_end && last_line) state_nx = capture_en ? ARM : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      fifo_wr_req <= 1'b0;
      fifo_wr_data <= '0;
      frame_done <= 1'b0;
      overflow <= 1'b0;
      line_err <= 1'b0;
      line_cnt <= '0;
    end else begin
      fifo_wr_req <= wr;
      if (wr) fifo_wr_data <= p_px;
      frame_done <= state == FRAME && line_end && last_line && !bad_line && !p_vs;
      overflow <= (state == IDLE && capture_en) ? 1'b0 : overflow | (state == FRAME && pix && fifo_full);
      line_err <= (state == IDLE && capture_en) ? 1'b0 : line_err | (state == FRAME && (p_vs || bad_line));
      if (enter || (state == FRAME && p_vs)) line_cnt <= '0;
      else if (state == FRAME && line_end) line_cnt <= last_line ? '0 : line_cnt + LW'(1);
    end
  // Frame entry rewinds row/col but keeps the page so a dropped frame rewrites the same page
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      row_add_user <= '0;
      col_add_user <= '0;
      page_set <= '0;
    end else if (enter) begin
      row_add_user <= '0;
      col_add_user <= '0;
    end else if (wr_inc) begin
      col_add_user <= col_add_user == 10'(H_ACTIVE - 1) ? '0 : col_add_user + 10'd1;
      if (col_add_user == 10'(H_ACTIVE - 1)) begin
        row_add_user <= row_add_user == 9'(V_ACTIVE - 1) ? '0 : row_add_user + 9'd1;
        if (row_add_user == 9'(V_ACTIVE - 1)) page_set <= page_set == 3'(PAGES - 1) ? '0 : page_set + 3'd1;
      end
    end
endmodule

// File: tb/tb_tft_frame_capture.sv
// tb_tft_frame_capture: directed bench for tft_frame_capture on a reduced 8x4 geometry with a frame-level reference model.
module tb_tft_frame_capture;
  localparam int H = 8, V = 4, P = 2;
`ifdef TFT_CAP_LINE_CHECK_EN
  localparam bit LCHK = 1'b1;
`else
  localparam bit LCHK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, capture_en = 1'b0, vin_dclk = 1'b0, vin_de = 1'b0, vin_vs = 1'b0;
  logic fifo_full = 1'b0, wr_inc = 1'b0;
  logic [5:0] vin_r = '0, vin_g = '0, vin_b = '0;
  logic fifo_wr_req, frame_done, overflow, line_err;
  logic [15:0] fifo_wr_data;
  logic [8:0] row_add_user;
  logic [9:0] col_add_user;
  logic [2:0] page_set;
  int compared = 0, mismatched = 0, cyc = 0, n_wr = 0, n_fd = 0;
  int first_wr_cyc = -1, first_rise = 0, w0, f0;
  logic [15:0] first_wr_data = '0;
  bit rec_rise = 1'b0;
  int wr_due[$], fd_due[$];
  logic [15:0] wr_dat[$];
  bit m_wait, m_cap, m_drop, m_last_de, m_ovf, m_lerr;
  int m_lines, m_pix, m_lin, m_page;

  tft_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .PAGES(P)) dut (
    .clk(clk), .rst(rst), .capture_en(capture_en), .vin_dclk(vin_dclk), .vin_de(vin_de),
    .vin_vs(vin_vs), .vin_r(vin_r), .vin_g(vin_g), .vin_b(vin_b), .fifo_wr_req(fifo_wr_req),
    .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full), .wr_inc(wr_inc),
    .row_add_user(row_add_user), .col_add_user(col_add_user), .page_set(page_set),
    .frame_done(frame_done), .overflow(overflow), .line_err(line_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    bit ew, ef;
    ew = wr_due.size() > 0 && wr_due[0] == cyc;
    ef = fd_due.size() > 0 && fd_due[0] == cyc;
    if (ew || fifo_wr_req === 1'b1) begin
      compared++;
      if (fifo_wr_req !== ew || (ew && fifo_wr_data !== wr_dat[0])) begin
        mismatched++;
        $display("FAIL wr @%0d: got req=%b data=%h, want req=%b data=%h", cyc, fifo_wr_req, fifo_wr_data, ew, ew ? wr_dat[0] : 16'h0);
      end
    end
    if (ef || frame_done === 1'b1) begin
      compared++;
      if (frame_done !== ef) begin
        mismatched++;
        $display("FAIL frame_done @%0d: got %b, want %b", cyc, frame_done, ef);
      end
    end
    if (fifo_wr_req === 1'b1) begin
      if (n_wr == 0) begin
        first_wr_cyc = cyc;
        first_wr_data = fifo_wr_data;
      end
      n_wr++;
    end
    if (frame_done === 1'b1) n_fd++;
    if (ew) begin
      void'(wr_due.pop_front());
      void'(wr_dat.pop_front());
    end
    if (ef) void'(fd_due.pop_front());
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, want %0h", nm, got, exp);
    end
  endtask

  function automatic logic [17:0] px(input int l, input int p);
    return (l == 0 && p == 0) ? {6'h3F, 6'h15, 6'h01} : {6'(l * 9 + p), 6'(50 - l - p * 3), 6'(p * 7 + l + 2)};
  endfunction

  function automatic void model_reset();
    wr_due.delete(); wr_dat.delete(); fd_due.delete();
    {m_wait, m_cap, m_drop, m_last_de, m_ovf, m_lerr} = '0;
    m_lines = 0; m_pix = 0; m_lin = 0; m_page = 0;
  endfunction

  function automatic void vs_model();
    m_pix = 0;
    if (m_wait || m_drop) begin
      {m_wait, m_drop, m_cap} = 3'b001;
      m_lines = 0;
      m_lin = 0;
    end else if (m_cap) begin
      m_lerr = 1'b1;
      m_lines = 0;
      m_cap = capture_en;
    end
  endfunction

  task automatic set_en(input bit e);
    capture_en = e;
    if (e && !(m_wait || m_cap || m_drop)) begin
      m_wait = 1'b1; m_ovf = 1'b0; m_lerr = 1'b0;
    end
    if (!e) begin
      m_wait = 1'b0; m_drop = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  // One panel pixel clock: 2 clk low then 2 clk high; fifo_full changes with the rise and is held for the next 4 clk
  task automatic dclk_pulse(input bit de, input bit full, input logic [17:0] d);
    vin_dclk = 1'b0; vin_de = de; {vin_r, vin_g, vin_b} = d;
    repeat (2) @(negedge clk);
    vin_dclk = 1'b1; fifo_full = full;
    if (rec_rise) begin
      first_rise = cyc; rec_rise = 1'b0;
    end
    if (de) begin
      m_pix++;
      if (m_cap && full) begin
        m_ovf = 1'b1; m_cap = 1'b0; m_drop = 1'b1;
      end else if (m_cap) begin
        wr_due.push_back(cyc + 4);
        wr_dat.push_back({d[17:13], d[11:6], d[5:1]});
      end
    end else if (m_last_de) begin
      if (m_cap && LCHK && m_pix != H) begin
        m_lerr = 1'b1; m_cap = 1'b0; m_drop = 1'b1;
      end else if (m_cap) begin
        m_lines++;
        if (m_lines == V) begin
          fd_due.push_back(cyc + 4);
          m_cap = 1'b0; m_wait = capture_en;
        end
      end
      m_pix = 0;
    end
    m_last_de = de;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_line(input int l, input int n, input int full_at);
    for (int p = 0; p < n; p++) dclk_pulse(1'b1, p == full_at, px(l, p));
    dclk_pulse(1'b0, 1'b0, '0);
    repeat (3) @(negedge clk);
  endtask

  task automatic vs_pulse();
    vin_vs = 1'b1; vin_de = 1'b0; vin_dclk = 1'b0;
    vs_model();
    repeat (6) @(negedge clk);
    vin_vs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic inc(input int n);
    for (int i = 0; i < n; i++) begin
      wr_inc = 1'b1;
      @(negedge clk);
      m_lin++;
      if (m_lin == H * V) begin
        m_lin = 0; m_page = (m_page + 1) % P;
      end
    end
    wr_inc = 1'b0;
  endtask

  task automatic check_addr();
    chk("row", row_add_user, m_lin / H);
    chk("col", col_add_user, m_lin % H);
    chk("page", page_set, m_page);
  endtask

  task automatic check_flags();
    repeat (4) @(negedge clk);
    chk("overflow", overflow, m_ovf);
    chk("line_err", line_err, m_lerr);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req"}, fifo_wr_req, 0);
    chk({tag, "_data"}, fifo_wr_data, 0);
    chk({tag, "_row"}, row_add_user, 0);
    chk({tag, "_col"}, col_add_user, 0);
    chk({tag, "_page"}, page_set, 0);
    chk({tag, "_fd"}, frame_done, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_lerr"}, line_err, 0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("rst");
    rst = 1'b1;
    @(negedge clk);
    // full frame
    set_en(1'b1);
    vs_pulse();
    rec_rise = 1'b1;
    w0 = n_wr; f0 = n_fd;
    for (int l = 0; l < V; l++) send_line(l, H, -1);
    chk("frame_writes", n_wr - w0, 32);
    chk("frame_done_cnt", n_fd - f0, 1);
    chk("pack_first", first_wr_data, 16'hFAA0);
    chk("latency", first_wr_cyc - (first_rise + 1), 3);
    check_flags();
    chk("ovf_clean", overflow, 0);
    inc(5);
    check_addr();
    chk("col_5", col_add_user, 5);
    inc(8);
    check_addr();
    chk("row_1", row_add_user, 1);
    chk("col_5b", col_add_user, 5);
    // overflow on pixel 3 of line 2
    vs_pulse();
    check_addr();
    chk("arm_clear_col", col_add_user, 0);
    w0 = n_wr;
    send_line(0, H, -1);
    send_line(1, H, -1);
    send_line(2, H, 3);
    chk("ovf_writes", n_wr - w0, 19);
    check_flags();
    chk("ovf_set", overflow, 1);
    inc(3);
    check_addr();
    vs_pulse();
    check_addr();
    chk("drop_row", row_add_user, 0);
    chk("drop_page", page_set, 0);
    w0 = n_wr; f0 = n_fd;
    for (int l = 0; l < V; l++) send_line(l, H, -1);
    chk("resume_writes", n_wr - w0, 32);
    chk("resume_fd", n_fd - f0, 1);
    check_flags();
    // early vs restarts the frame
    vs_pulse();
    send_line(0, H, -1);
    send_line(1, H, -1);
    vs_pulse();
    f0 = n_fd;
    for (int l = 0; l < V; l++) send_line(l, H, -1);
    check_flags();
    chk("restart_lerr", line_err, 1);
    chk("restart_fd", n_fd - f0, 1);
    // re-arm clears the sticky flags
    set_en(1'b0);
    set_en(1'b1);
    check_flags();
    chk("rearm_ovf", overflow, 0);
    chk("rearm_lerr", line_err, 0);
    // short line
    vs_pulse();
    w0 = n_wr;
    send_line(0, H - 1, -1);
    chk("short_writes", n_wr - w0, 7);
    check_flags();
    chk("short_lerr", line_err, LCHK);
    for (int l = 1; l < V; l++) send_line(l, H, -1);
    check_flags();
    // wr_inc coinciding with the frame-entry clear
    inc(3);
    check_addr();
    vin_vs = 1'b1;
    vs_model();
    repeat (3) @(negedge clk);
    wr_inc = 1'b1;
    @(negedge clk);
    wr_inc = 1'b0;
    repeat (3) @(negedge clk);
    vin_vs = 1'b0;
    repeat (4) @(negedge clk);
    check_addr();
    chk("clr_prio_col", col_add_user, 0);
    // address wrap and page advance
    inc(H * V - 1);
    check_addr();
    chk("wrap_row_end", row_add_user, 3);
    chk("wrap_col_end", col_add_user, 7);
    inc(1);
    check_addr();
    chk("page_1", page_set, 1);
    inc(H * V);
    check_addr();
    chk("page_0", page_set, 0);
    // reset with a pixel in flight
    w0 = n_wr;
    vin_de = 1'b1; vin_dclk = 1'b0; {vin_r, vin_g, vin_b} = px(1, 1);
    repeat (2) @(negedge clk);
    vin_dclk = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("midrst");
    vin_dclk = 1'b0; vin_de = 1'b0;
    rst = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst_nowr", n_wr - w0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
